// File: rtl/rx_fc_pkg.sv
// rx_fc_pkg: shared FSM state type, counter widths and saturating arithmetic for rx_frame_checker.
package rx_fc_pkg;
    typedef enum logic {IDLE, IN_FRAME} state_t;
    localparam int CNT_W = 16;
    localparam int BER_W = 32;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    function automatic logic [BER_W-1:0] sat_add(input logic [BER_W-1:0] v, input logic [3:0] d);
        logic [BER_W:0] s;
        s = {1'b0, v} + {{(BER_W-3){1'b0}}, d};
        return s[BER_W] ? '1 : s[BER_W-1:0];
    endfunction
endpackage

// File: rtl/rx_fc_popcount8.sv
// rx_fc_popcount8: combinational count of set bits in one byte.
module rx_fc_popcount8 (
    input  logic [7:0] data,
    output logic [3:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) count = count + {3'b000, data[i]};
    end
endmodule

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: checks incrementing-byte test frames, counts frames/errors and tracks link lock.
// Define RX_FC_BER_EN to enable the payload bit-error counter.
module rx_frame_checker
    import rx_fc_pkg::*;
#(
    parameter int         FRAME_LEN    = 64,
    parameter logic [7:0] PAYLOAD_BASE = 8'h00,
    parameter int         LOCK_FRAMES  = 4
) (
    input  logic             clk_32M768,
    input  logic             rst_n_32M768,
    input  logic [7:0]       data_tdata,
    input  logic             data_tvalid,
    input  logic             data_tuser,
    input  logic             data_tlast,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [BER_W-1:0] bit_err_cnt,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             locked
);
    state_t     state;
    logic [7:0] idx;
    logic [3:0] run;
    logic       bad;
    logic [7:0] expected;
    logic       mismatch, last_pos, close, close_ok;
    logic [4:0] run_inc;

    // a tuser beat always restarts the comparison at byte 0
    assign expected = PAYLOAD_BASE + (data_tuser ? 8'd0 : idx);
    assign mismatch = data_tdata != expected;
    assign last_pos = idx == 8'(FRAME_LEN - 1);
    assign run_inc  = {1'b0, run} + 5'd1;
    assign close    = data_tvalid && ((state == IN_FRAME) ? (data_tuser || data_tlast || last_pos)
                                                          : (data_tuser && data_tlast));
    assign close_ok = state == IN_FRAME && !data_tuser && data_tlast && last_pos && !bad && !mismatch;

    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            state         <= IDLE;
            idx           <= '0;
            bad           <= 1'b0;
            run           <= '0;
            frame_cnt     <= '0;
            frame_err_cnt <= '0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            locked        <= 1'b0;
        end else begin
            frame_done <= close;
            if (data_tvalid && data_tuser && !data_tlast) begin
                state <= IN_FRAME;
                idx   <= 8'd1;
                bad   <= mismatch;
            end else if (close) begin
                state <= IDLE;
                idx   <= '0;
                bad   <= 1'b0;
            end else if (data_tvalid && state == IN_FRAME) begin
                idx <= idx + 8'd1;
                bad <= bad | mismatch;
            end
            if (close) begin
                frame_ok <= close_ok;
                run      <= close_ok ? (run_inc > 5'(LOCK_FRAMES) ? run : run_inc[3:0]) : '0;
                locked   <= close_ok && run_inc >= 5'(LOCK_FRAMES);
            end
            if (clr_stats) begin
                frame_cnt     <= '0;
                frame_err_cnt <= '0;
            end else if (close) begin
                frame_cnt <= sat_inc(frame_cnt);
                if (!close_ok) frame_err_cnt <= sat_inc(frame_err_cnt);
            end
        end
    end

`ifdef RX_FC_BER_EN
    logic [3:0] flips;
    logic       checked;
    assign checked = data_tvalid && (data_tuser || state == IN_FRAME);
    rx_fc_popcount8 u_popcount (.data(data_tdata ^ expected), .count(flips));
    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768 || clr_stats) bit_err_cnt <= '0;
        else if (checked) bit_err_cnt <= sat_add(bit_err_cnt, flips);
    end
`else
    assign bit_err_cnt = '0;
`endif
endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker: randomized frame stimulus checked beat-by-beat against a frame-level model.
module tb_rx_frame_checker;
    localparam int         FL   = 64;
    localparam logic [7:0] BASE = 8'h00;
    localparam int         LK   = 4;

    typedef struct packed {logic v; logic u; logic l; logic c; logic [7:0] d;} beat_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  tdata = '0;
    logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, clr_stats = 1'b0;
    logic [15:0] frame_cnt, frame_err_cnt;
    logic [31:0] bit_err_cnt;
    logic        frame_done, frame_ok, locked;
    int compared = 0, mismatched = 0;

    // model: bytes of the open frame are judged as a whole when it closes
    logic [7:0] cur[$];
    bit         open, m_done, m_ok, m_locked;
    int         m_cnt, m_err, m_run;
    longint     m_ber;
    beat_t      bq[$];

    rx_frame_checker #(.FRAME_LEN(FL), .PAYLOAD_BASE(BASE), .LOCK_FRAMES(LK)) dut (
        .clk_32M768(clk), .rst_n_32M768(rst_n), .data_tdata(tdata), .data_tvalid(tvalid),
        .data_tuser(tuser), .data_tlast(tlast), .clr_stats(clr_stats), .frame_cnt(frame_cnt),
        .frame_err_cnt(frame_err_cnt), .bit_err_cnt(bit_err_cnt), .frame_done(frame_done),
        .frame_ok(frame_ok), .locked(locked));

    always #5 clk = ~clk;

    function automatic logic [66:0] obs();
        return {frame_done, frame_ok, locked, frame_cnt, frame_err_cnt, bit_err_cnt};
    endfunction

    function automatic logic [66:0] expv();
        return {m_done, m_ok, m_locked, 16'(m_cnt), 16'(m_err), 32'(m_ber)};
    endfunction

    task automatic model_reset();
        cur.delete(); open = 0; m_done = 0; m_ok = 0; m_locked = 0;
        m_cnt = 0; m_err = 0; m_run = 0; m_ber = 0;
    endtask

    task automatic judge(input bit by_tlast);
        bit good;
        good = by_tlast && cur.size() == FL;
        foreach (cur[i]) if (cur[i] != 8'(int'(BASE) + i)) good = 0;
        m_done = 1; m_ok = good;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        if (!good) m_err = (m_err < 65535) ? m_err + 1 : m_err;
        m_run = good ? m_run + 1 : 0;
        m_locked = m_run >= LK;
        cur.delete(); open = 0;
    endtask

    task automatic add_byte(input logic [7:0] d);
`ifdef RX_FC_BER_EN
        m_ber = m_ber + longint'($countones(d ^ 8'(int'(BASE) + cur.size())));
        if (m_ber > 64'hFFFF_FFFF) m_ber = 64'hFFFF_FFFF;
`endif
        cur.push_back(d);
    endtask

    task automatic beat(input beat_t b);
        tvalid = b.v; tuser = b.u; tlast = b.l; clr_stats = b.c; tdata = b.d;
        m_done = 0;
        if (b.v && b.u) begin
            if (open) judge(0);
            open = 1; add_byte(b.d);
            if (b.l) judge(1);
        end else if (b.v && open) begin
            add_byte(b.d);
            if (b.l) judge(1);
            else if (cur.size() == FL) judge(0);
        end
        if (b.c) begin m_cnt = 0; m_err = 0; m_ber = 0; end
        @(posedge clk); #1;
        tvalid = 0; tuser = 0; tlast = 0; clr_stats = 0;
    endtask

    task automatic push_frame(input int len, input bit tl, input int ci, input logic [7:0] mask, input bit cl);
        for (int i = 0; i < len; i++)
            bq.push_back('{1'b1, i == 0, tl && i == len - 1, cl && i == len - 1,
                           8'(int'(BASE) + i) ^ (i == ci ? mask : 8'h00)});
    endtask

    task automatic push_gap(input int n);
        for (int i = 0; i < n; i++) bq.push_back('{1'($urandom), 1'b0, 1'($urandom), 1'b0, 8'($urandom)});
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        for (int i = 0; i < n; i++) begin
            tvalid = 1'($urandom); tuser = 1'($urandom); tlast = 1'($urandom);
            clr_stats = 1'($urandom); tdata = 8'($urandom);
            @(posedge clk); #1;
        end
        model_reset();
        rst_n = 1; tvalid = 0; tuser = 0; tlast = 0; clr_stats = 0;
    endtask

    task automatic test_reset();
        do_reset(3);
        compared++;
        if (obs() !== 67'd0) begin
            mismatched++; $display("FAIL reset_state: dut=%h want=0", obs());
        end
        repeat (2) begin
            beat('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL reset_idle: dut=%h model=%h", obs(), expv()); end
        end
    endtask

    task automatic test_clean();
        bq.delete();
        for (int f = 0; f < 10; f++) begin push_gap($urandom_range(0, 3)); push_frame(FL, 1, -1, 8'h00, 0); end
        push_gap(2);
        foreach (bq[i]) begin
            beat(bq[i]);
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL clean beat %0d: dut=%h model=%h", i, obs(), expv()); end
            if (i == 4 * FL + 3) begin end
        end
        compared++;
        if (frame_cnt !== 16'd10 || frame_err_cnt !== 16'd0 || locked !== 1'b1) begin
            mismatched++;
            $display("FAIL clean_totals: cnt=%0d err=%0d locked=%b want 10/0/1", frame_cnt, frame_err_cnt, locked);
        end
    endtask

    task automatic test_byte_err();
        int pre_err;
        longint pre_ber;
        pre_err = m_err; pre_ber = m_ber;
        bq.delete();
        push_frame(FL, 1, 5, 8'h81, 0);
        push_gap(1);
        foreach (bq[i]) begin
            beat(bq[i]);
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL byte_err beat %0d: dut=%h model=%h", i, obs(), expv()); end
        end
        compared++;
`ifdef RX_FC_BER_EN
        pre_ber = pre_ber + 2;
`endif
        if (frame_ok !== 1'b0 || locked !== 1'b0 || frame_err_cnt !== 16'(pre_err + 1) || bit_err_cnt !== 32'(pre_ber)) begin
            mismatched++;
            $display("FAIL byte_err_totals: ok=%b locked=%b err=%0d ber=%0d want 0/0/%0d/%0d",
                     frame_ok, locked, frame_err_cnt, bit_err_cnt, pre_err + 1, pre_ber);
        end
    endtask

    task automatic test_length();
        bq.delete();
        push_frame(FL - 1, 1, -1, 8'h00, 0);
        push_gap(2);
        push_frame(FL + 6, 1, -1, 8'h00, 0);
        push_frame(FL, 1, -1, 8'h00, 0);
        foreach (bq[i]) begin
            beat(bq[i]);
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL length beat %0d: dut=%h model=%h", i, obs(), expv()); end
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        bq.delete();
        push_frame(30, 0, -1, 8'h00, 0);
        push_frame(FL, 1, -1, 8'h00, 0);
        foreach (bq[i]) begin
            beat(bq[i]);
            dones += int'(frame_done);
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL abort beat %0d: dut=%h model=%h", i, obs(), expv()); end
        end
        compared++;
        if (dones !== 2 || frame_ok !== 1'b1) begin
            mismatched++; $display("FAIL abort_totals: dones=%0d ok=%b want 2/1", dones, frame_ok);
        end
    endtask

    task automatic test_clr();
        bq.delete();
        push_frame(FL, 1, -1, 8'h00, 0);
        push_frame(FL, 1, 9, 8'h0F, 1);
        push_gap(1);
        foreach (bq[i]) begin
            beat(bq[i]);
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL clr beat %0d: dut=%h model=%h", i, obs(), expv()); end
        end
        compared++;
        if (frame_cnt !== 16'd0 || frame_err_cnt !== 16'd0 || bit_err_cnt !== 32'd0) begin
            mismatched++;
            $display("FAIL clr_totals: cnt=%0d err=%0d ber=%0d want 0", frame_cnt, frame_err_cnt, bit_err_cnt);
        end
    endtask

    task automatic test_random();
        bq.delete();
        for (int f = 0; f < 40; f++) begin
            int kind;
            kind = $urandom_range(0, 4);
            case (kind)
                0: push_frame(FL, 1, -1, 8'h00, 0);
                1: push_frame(FL, 1, $urandom_range(0, FL - 1), 8'($urandom_range(1, 255)), 0);
                2: push_frame($urandom_range(2, FL - 1), 1, -1, 8'h00, 0);
                3: push_frame($urandom_range(FL, FL + 5), 0, -1, 8'h00, 0);
                default: push_frame($urandom_range(2, FL - 1), 0, -1, 8'h00, 0);
            endcase
            if (kind != 4) push_gap($urandom_range(0, 3));
        end
        push_frame(FL, 1, -1, 8'h00, 0);
        foreach (bq[i]) begin
            if ($urandom_range(0, 49) == 0) bq[i].c = 1'b1;
            beat(bq[i]);
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL random beat %0d: dut=%h model=%h", i, obs(), expv()); end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 65540; i++) begin
            beat('{1'b1, 1'b1, 1'b1, 1'b0, 8'($urandom)});
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL saturate beat %0d: dut=%h model=%h", i, obs(), expv()); end
        end
        compared++;
        if (frame_err_cnt !== 16'hFFFF || frame_cnt !== 16'hFFFF) begin
            mismatched++; $display("FAIL saturate_hold: cnt=%h err=%h want ffff", frame_cnt, frame_err_cnt);
        end
        beat('{1'b1, 1'b1, 1'b1, 1'b1, 8'h00});
        compared++;
        if (frame_err_cnt !== 16'd0 || frame_cnt !== 16'd0 || frame_done !== 1'b1) begin
            mismatched++;
            $display("FAIL saturate_clr: cnt=%h err=%h done=%b want 0/0/1", frame_cnt, frame_err_cnt, frame_done);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        bq.delete();
        push_frame(20, 0, -1, 8'h00, 0);
        foreach (bq[i]) beat(bq[i]);
        do_reset(2);
        bq.delete();
        push_frame(FL - 20, 0, -1, 8'h00, 0);
        push_frame(FL, 1, -1, 8'h00, 0);
        push_gap(2);
        foreach (bq[i]) begin
            if (i < FL - 20) bq[i].u = 1'b0;
            beat(bq[i]);
            dones += int'(frame_done);
            compared++;
            if (obs() !== expv()) begin mismatched++; $display("FAIL reset_mid beat %0d: dut=%h model=%h", i, obs(), expv()); end
        end
        compared++;
        if (dones !== 1 || frame_cnt !== 16'd1 || frame_ok !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_mid_totals: dones=%0d cnt=%0d ok=%b want 1/1/1", dones, frame_cnt, frame_ok);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean();
        test_byte_err();
        test_length();
        test_abort();
        test_clr();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
